// File: rtl/ps2_scan_event_fifo.sv
// PS/2 keyboard receiver: frame deserialiser, E0/F0 prefix decoder, optional
// typematic-repeat filter and a show-ahead event FIFO with valid/ready read side.
module ps2_scan_event_fifo #(
    parameter int DEPTH         = 8,
    parameter int CNT_W         = 8,
    parameter int TIMEOUT_CYC   = 50000,
    parameter int FILTER_REPEAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ps2_clk,
    input  logic                       ps2_data,
    input  logic                       evt_ready,
    input  logic                       clr_ovf,
    output logic                       evt_valid,
    output logic [9:0]                 evt_data,
    output logic [$clog2(DEPTH):0]     evt_level,
    output logic                       ovf,
    output logic                       frame_err,
    output logic [CNT_W-1:0]           press_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} dec_state_t;

    logic [2:0]    sync_clk, sync_data;
    logic          fall;
    logic [9:0]    shift;
    logic [10:0]   frame;
    logic          frame_ok;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] idle_cnt;
    logic          rx_valid;
    logic [7:0]    rx_byte;

    assign fall     = (sync_clk[2:1] == 2'b10);
    assign frame    = {sync_data[2], shift};
    assign frame_ok = !frame[0] && frame[10] && (^frame[9:1]);

    // Sync flops reset high so the idle-high line does not look like a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_clk  <= '1;
            sync_data <= '1;
        end else begin
            sync_clk  <= {sync_clk[1:0], ps2_clk};
            sync_data <= {sync_data[1:0], ps2_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift     <= '0;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
            rx_valid  <= 1'b0;
            rx_byte   <= '0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (fall) begin
                idle_cnt <= '0;
                shift    <= {sync_data[2], shift[9:1]};
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (frame_ok) begin
                        rx_valid <= 1'b1;
                        rx_byte  <= frame[8:1];
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (bit_cnt != '0) begin
                if (idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    bit_cnt   <= '0;
                    idle_cnt  <= '0;
                    frame_err <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

    dec_state_t state, state_nxt;
    logic       ev_valid, ev_ext, ev_brk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // A repeated F0 keeps whichever extended/non-extended break state is pending.
    always_comb begin
        state_nxt = state;
        ev_valid  = 1'b0;
        ev_ext    = 1'b0;
        ev_brk    = 1'b0;
        if (rx_valid) begin
            if (rx_byte == 8'hE0) begin
                state_nxt = S_E0;
            end else if (rx_byte == 8'hF0) begin
                state_nxt = (state == S_E0 || state == S_E0F0) ? S_E0F0 : S_F0;
            end else begin
                ev_valid  = 1'b1;
                ev_ext    = (state == S_E0 || state == S_E0F0);
                ev_brk    = (state == S_F0 || state == S_E0F0);
                state_nxt = S_IDLE;
            end
        end
    end

    logic       held_v, held_ext;
    logic [7:0] held_code;
    logic       held_match, ev_accept;

    assign held_match = held_v && (held_ext == ev_ext) && (held_code == rx_byte);
    assign ev_accept  = ev_valid && !((FILTER_REPEAT != 0) && !ev_brk && held_match);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_v    <= 1'b0;
            held_ext  <= 1'b0;
            held_code <= '0;
        end else if ((FILTER_REPEAT != 0) && ev_valid) begin
            if (!ev_brk && !held_match) begin
                held_v    <= 1'b1;
                held_ext  <= ev_ext;
                held_code <= rx_byte;
            end else if (ev_brk && held_match) begin
                held_v <= 1'b0;
            end
        end
    end

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, pop, push, drop;

    assign evt_valid = (evt_level != '0);
    assign evt_data  = evt_valid ? mem[rd_ptr] : '0;
    assign full      = (evt_level == (AW+1)'(DEPTH));
    assign pop       = evt_valid && evt_ready;
    assign push      = ev_accept && (!full || pop);
    assign drop      = ev_accept && full && !pop;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {ev_ext, ev_brk, rx_byte};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            evt_level <= '0;
            ovf       <= 1'b0;
            press_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      evt_level <= evt_level + 1'b1;
            else if (pop && !push) evt_level <= evt_level - 1'b1;
            if (drop)         ovf <= 1'b1;
            else if (clr_ovf) ovf <= 1'b0;
            if (push && !ev_brk) press_cnt <= press_cnt + 1'b1;
        end
    end
endmodule
